// File: rtl/cellram_responder.sv
// Async-mode Cellular RAM (PSRAM) device model: decodes CS/OE/WR/ADV/LB/UB,
// drives MemDB on reads after READ_LAT, commits writes held >= WRITE_LAT.
// Ports: clk, rst (async active-low), MemDB (inout 16), MemAdv, MemClk,
//   RamCS, MemOE, MemWR, RamLB, RamUB, MemAdr[26:1]; out busy, rd_done,
//   wr_done, wr_err; MemWait (active-low) when CELLRAM_WAIT_EN is defined.
module cellram_responder #(
  parameter int ADDR_BITS = 8,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire  [15:0] MemDB,
  input  logic        MemAdv,
  input  logic        MemClk,
  input  logic        RamCS,
  input  logic        MemOE,
  input  logic        MemWR,
  input  logic        RamLB,
  input  logic        RamUB,
  input  logic [26:1] MemAdr,
  output logic        busy,
  output logic        rd_done,
  output logic        wr_done,
`ifdef CELLRAM_WAIT_EN
  output logic        MemWait,
`endif
  output logic        wr_err
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int MAXL  = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CW    = $clog2(MAXL) + 1;

  localparam logic [CW-1:0] RL   = CW'(READ_LAT);
  localparam logic [CW-1:0] WLM1 = CW'(WRITE_LAT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] CMAX = '1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RWAIT = 3'd1;
  localparam logic [2:0] RDRV  = 3'd2;
  localparam logic [2:0] WWAIT = 3'd3;
  localparam logic [2:0] WHOLD = 3'd4;

  logic [2:0]           st, nxt;
  logic [CW-1:0]        cnt, cnt_d, cnt_inc;
  logic [ADDR_BITS-1:0] a_q, a_d, adr;
  logic [15:0]          hold_q, rdat;
  logic                 lb_q, ub_q;
  logic                 rd_p, wr_p, er_p, cmt, smp;
  logic                 drv;
  logic [15:0]          mem [0:DEPTH-1];

  wire unused_ok = &{1'b0, MemClk, MemAdr[26:ADDR_BITS+1]};

  assign adr     = MemAdr[ADDR_BITS:1];
  assign busy    = (st != IDLE);
  assign cnt_inc = (cnt == CMAX) ? cnt : cnt + ONE;
  assign rdat    = mem[a_q];

  // Release is combinational so the bus frees in the cycle CS/OE rise.
  assign drv = (st == RDRV) && !RamCS && !MemOE;
  assign MemDB[15:8] = (drv && !RamUB) ? rdat[15:8] : 8'hzz;
  assign MemDB[7:0]  = (drv && !RamLB) ? rdat[7:0]  : 8'hzz;

  always_comb begin
    nxt   = st;
    cnt_d = cnt;
    a_d   = a_q;
    rd_p  = 1'b0;
    wr_p  = 1'b0;
    er_p  = 1'b0;
    cmt   = 1'b0;
    smp   = 1'b0;
    case (st)
      IDLE: begin
        if (!RamCS && !MemAdv) a_d = adr;
        if (!RamCS && !MemWR) begin
          nxt   = (WRITE_LAT <= 1) ? WHOLD : WWAIT;
          cnt_d = ONE;
          smp   = 1'b1;
        end else if (!RamCS && !MemOE) begin
          nxt   = RWAIT;
          cnt_d = ONE;
        end
      end
      RWAIT: begin
        if (RamCS || MemOE || !MemWR) begin
          nxt = IDLE;
        end else if (cnt >= RL) begin
          nxt  = RDRV;
          rd_p = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RDRV: begin
        if (RamCS || MemOE || !MemWR) begin
          nxt = IDLE;
        end else if (!MemAdv && adr != a_q) begin
          a_d   = adr;
          nxt   = RWAIT;
          cnt_d = ONE;
        end
      end
      WWAIT: begin
        if (MemWR || RamCS) begin
          nxt  = IDLE;
          er_p = 1'b1;
        end else begin
          // this edge is one more low sample; reaching WRITE_LAT arms commit
          smp   = 1'b1;
          cnt_d = cnt_inc;
          if (cnt >= WLM1) nxt = WHOLD;
        end
      end
      WHOLD: begin
        if (MemWR || RamCS) begin
          nxt  = IDLE;
          wr_p = 1'b1;
          cmt  = 1'b1;
        end else begin
          smp = 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      hold_q  <= '0;
      lb_q    <= 1'b1;
      ub_q    <= 1'b1;
      rd_done <= 1'b0;
      wr_done <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      st      <= nxt;
      cnt     <= cnt_d;
      a_q     <= a_d;
      rd_done <= rd_p;
      wr_done <= wr_p;
      wr_err  <= er_p;
      if (smp) begin
        hold_q <= MemDB;
        lb_q   <= RamLB;
        ub_q   <= RamUB;
      end
    end
  end

  // Array has no reset; reset forces IDLE so cmt cannot fire mid-reset.
  always_ff @(posedge clk) begin
    if (cmt) begin
      if (!lb_q) mem[a_q][7:0]  <= hold_q[7:0];
      if (!ub_q) mem[a_q][15:8] <= hold_q[15:8];
    end
  end

`ifdef CELLRAM_WAIT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) MemWait <= 1'b1;
    else      MemWait <= !(nxt == RWAIT || nxt == WWAIT);
  end
`endif

endmodule

// File: tb/tb_cellram_responder.sv
// Directed bench for cellram_responder: vector table of writes/reads plus
// hand sequences for reset, OE/WR priority and mid-access aborts.
module tb_cellram_responder;

  localparam int RL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemAdv = 1'b0, MemClk = 1'b0, RamCS = 1'b0;
  logic        MemOE = 1'b0, MemWR = 1'b1, RamLB = 1'b0, RamUB = 1'b0;
  logic [26:1] MemAdr = 26'h12;
  logic        busy, rd_done, wr_done, wr_err;
  logic [15:0] tb_db = 16'h0;
  logic        tb_den = 1'b0;
  wire  [15:0] MemDB;

  // Undriven bus reads as all-ones, so "released" shows as 8'hFF lanes.
  assign MemDB = tb_den ? tb_db : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (MemDB[i]);
  end

  cellram_responder #(.ADDR_BITS(8), .READ_LAT(RL), .WRITE_LAT(3)) dut (
    .clk(clk), .rst(rst), .MemDB(MemDB), .MemAdv(MemAdv),
    .MemClk(MemClk), .RamCS(RamCS), .MemOE(MemOE), .MemWR(MemWR),
    .RamLB(RamLB), .RamUB(RamUB), .MemAdr(MemAdr), .busy(busy),
    .rd_done(rd_done), .wr_done(wr_done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_rd = 0, n_wd = 0, n_er = 0;

  always @(negedge clk) begin
    if (rd_done) n_rd++;
    if (wr_done) n_wd++;
    if (wr_err)  n_er++;
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic idle_bus();
    RamCS = 1'b1; MemOE = 1'b1; MemWR = 1'b1; MemAdv = 1'b1;
    RamLB = 1'b1; RamUB = 1'b1; tb_den = 1'b0;
  endtask

  task automatic do_write(input logic [25:0] a, input logic [15:0] d,
                          input logic lb, input logic ub, input int n,
                          output int dn, output int er);
    int wd0, er0;
    @(negedge clk);
    wd0 = n_wd; er0 = n_er;
    RamCS = 1'b0; MemAdv = 1'b0; MemWR = 1'b0; MemOE = 1'b1;
    MemAdr = a; RamLB = lb; RamUB = ub; tb_db = d; tb_den = 1'b1;
    repeat (n) @(negedge clk);
    idle_bus();
    repeat (3) @(negedge clk);
    dn = n_wd - wd0;
    er = n_er - er0;
  endtask

  task automatic do_read(input logic [25:0] a, input logic lb,
                         input logic ub, output logic [15:0] d,
                         output logic early_z, output int nr);
    int rd0;
    @(negedge clk);
    rd0 = n_rd;
    RamCS = 1'b0; MemOE = 1'b0; MemWR = 1'b1; MemAdv = 1'b0;
    MemAdr = a; RamLB = lb; RamUB = ub; tb_den = 1'b0;
    early_z = 1'b1;
    repeat (RL) begin
      @(negedge clk);
      if (MemDB !== 16'hFFFF) early_z = 1'b0;
    end
    @(negedge clk);
    d = MemDB;
    repeat (2) @(negedge clk);
    idle_bus();
    repeat (2) @(negedge clk);
    nr = n_rd - rd0;
  endtask

  typedef struct {
    bit          rd;
    logic [25:0] a;
    logic [15:0] d;
    bit          lb;
    bit          ub;
    int          n;
    logic [15:0] exp;
    int          edone;
    int          eerr;
  } vec_t;

  vec_t v[15];

  initial begin
    logic [15:0] d;
    logic        ez;
    int          c1, c2;

    v[0]  = '{0, 26'h12,  16'hA55A, 0, 0, 5, 16'h0,    1, 0};
    v[1]  = '{1, 26'h12,  16'h0,    0, 0, 0, 16'hA55A, 0, 0};
    v[2]  = '{0, 26'h12,  16'h1234, 0, 1, 5, 16'h0,    1, 0};
    v[3]  = '{1, 26'h12,  16'h0,    0, 0, 0, 16'hA534, 0, 0};
    v[4]  = '{1, 26'h12,  16'h0,    1, 0, 0, 16'hA5FF, 0, 0};
    v[5]  = '{0, 26'h12,  16'hBEEF, 0, 0, 2, 16'h0,    0, 1};
    v[6]  = '{1, 26'h12,  16'h0,    0, 0, 0, 16'hA534, 0, 0};
    v[7]  = '{0, 26'h112, 16'h6C3B, 0, 0, 3, 16'h0,    1, 0};
    v[8]  = '{1, 26'h12,  16'h0,    0, 0, 0, 16'h6C3B, 0, 0};
    v[9]  = '{0, 26'h34,  16'h5AC3, 0, 0, 4, 16'h0,    1, 0};
    v[10] = '{0, 26'h34,  16'h0F0F, 1, 1, 4, 16'h0,    1, 0};
    v[11] = '{1, 26'h34,  16'h0,    0, 0, 0, 16'h5AC3, 0, 0};
    v[12] = '{0, 26'hFF,  16'h7E81, 0, 0, 3, 16'h0,    1, 0};
    v[13] = '{1, 26'h1FF, 16'h0,    0, 0, 0, 16'h7E81, 0, 0};
    v[14] = '{1, 26'h34,  16'h0,    0, 1, 0, 16'hFFC3, 0, 0};

    // reset held with a read request pending
    repeat (3) @(negedge clk);
    chk("rst_bus", MemDB, 16'hFFFF);
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd_done, 0);
    chk("rst_wd", wr_done, 0);
    chk("rst_er", wr_err, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_busy", busy, 1);
    idle_bus();
    repeat (2) @(negedge clk);
    chk("rel_idle", busy, 0);

    for (int i = 0; i < 15; i++) begin
      if (v[i].rd) begin
        do_read(v[i].a, v[i].lb, v[i].ub, d, ez, c1);
        chk($sformatf("v%0d_early", i), ez, 1);
        chk($sformatf("v%0d_data", i), d, v[i].exp);
        chk($sformatf("v%0d_rdn", i), c1, 1);
      end else begin
        do_write(v[i].a, v[i].d, v[i].lb, v[i].ub, v[i].n, c1, c2);
        chk($sformatf("v%0d_wdn", i), c1, v[i].edone);
        chk($sformatf("v%0d_err", i), c2, v[i].eerr);
      end
    end

    // OE and WR low together: write path, bus never driven
    @(negedge clk);
    c1 = n_wd; c2 = n_rd; ez = 1'b1;
    RamCS = 1'b0; MemOE = 1'b0; MemWR = 1'b0; MemAdv = 1'b0;
    MemAdr = 26'h56; RamLB = 1'b0; RamUB = 1'b0; tb_den = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (MemDB !== 16'hFFFF) ez = 1'b0;
    end
    idle_bus();
    repeat (3) @(negedge clk);
    chk("prio_nodrv", ez, 1);
    chk("prio_wdn", n_wd - c1, 1);
    chk("prio_rdn", n_rd - c2, 0);
    do_read(26'h56, 0, 0, d, ez, c1);
    chk("prio_data", d, 16'hFFFF);

    // reset during WRITE_HOLD: no commit
    @(negedge clk);
    c1 = n_wd;
    RamCS = 1'b0; MemAdv = 1'b0; MemWR = 1'b0; MemOE = 1'b1;
    MemAdr = 26'h12; RamLB = 1'b0; RamUB = 1'b0;
    tb_db = 16'h0BAD; tb_den = 1'b1;
    repeat (5) @(negedge clk);
    chk("hold_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("rsth_busy", busy, 0);
    idle_bus();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rsth_wdn", n_wd - c1, 0);
    do_read(26'h12, 0, 0, d, ez, c2);
    chk("rsth_data", d, 16'h6C3B);

    // OE rises while driving: bus frees within the same cycle
    @(negedge clk);
    RamCS = 1'b0; MemOE = 1'b0; MemWR = 1'b1; MemAdv = 1'b0;
    MemAdr = 26'h34; RamLB = 1'b0; RamUB = 1'b0;
    repeat (RL + 1) @(negedge clk);
    chk("oe_drv", MemDB, 16'h5AC3);
    MemOE = 1'b1;
    #1;
    chk("oe_rel", MemDB, 16'hFFFF);
    @(negedge clk);
    chk("oe_idle", busy, 0);
    idle_bus();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
